// File: rtl/demux_1x4_buf.sv
// One-to-four demultiplexer with a one-entry skid-free buffer per output lane.
// A lane can load and drain in the same cycle, so a streaming lane never bubbles.
module demux_1x4_buf #(
  parameter int Bits = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [Bits-1:0] in_data,
  input  logic [1:0]      in_sel,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [Bits-1:0] out_a,
  output logic [Bits-1:0] out_b,
  output logic [Bits-1:0] out_c,
  output logic [Bits-1:0] out_d,
  output logic [3:0]      out_valid,
  input  logic [3:0]      out_ready,
  output logic [15:0]     accept_cnt
);

  logic [3:0]      lane_valid;
  logic [Bits-1:0] lane_data [4];
  logic            accept;

  // A full lane still accepts when its consumer drains it in the same cycle.
  assign in_ready = !rst && (!lane_valid[in_sel] || out_ready[in_sel]);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_valid <= '0;
      accept_cnt <= '0;
      for (int i = 0; i < 4; i++) begin
        lane_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        // Load has priority over drain so a simultaneous drain+load keeps valid high.
        if (accept && (in_sel == 2'(i))) begin
          lane_data[i]  <= in_data;
          lane_valid[i] <= 1'b1;
        end else if (lane_valid[i] && out_ready[i]) begin
          lane_valid[i] <= 1'b0;
        end
      end
      if (accept) begin
        accept_cnt <= accept_cnt + 16'd1;
      end
    end
  end

  assign out_valid = lane_valid;
  assign out_a     = lane_data[0];
  assign out_b     = lane_data[1];
  assign out_c     = lane_data[2];
  assign out_d     = lane_data[3];

endmodule

// File: tb/tb_demux_1x4_buf.sv
// Directed self-checking bench for demux_1x4_buf; each task drives one scenario
// and compares outputs against hand-computed values.
module tb_demux_1x4_buf;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_a, out_b, out_c, out_d;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] accept_cnt;

  int checks = 0;
  int passes = 0;

  demux_1x4_buf #(.Bits(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_c      (out_c),
    .out_d      (out_d),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .accept_cnt (accept_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h55; out_ready = 4'b0000;
    applyStimulus();
    checks++;
    if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready got=%b exp=0", in_ready); else passes++;
    applyStimulus();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0000) $display("[TB] FAIL reset_out_valid got=%b exp=0000", out_valid); else passes++;
    checks++;
    if ({out_a, out_b, out_c, out_d} !== 128'h0) $display("[TB] FAIL reset_data got=%h %h %h %h exp=0", out_a, out_b, out_c, out_d); else passes++;
    checks++;
    if (accept_cnt !== 16'd0) $display("[TB] FAIL reset_cnt got=%0d exp=0", accept_cnt); else passes++;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL post_reset_in_ready got=%b exp=1", in_ready); else passes++;
  endtask

  task automatic test_route();
    in_sel = 2'b10; in_data = 32'hDEADBEEF; in_valid = 1'b1; out_ready = 4'b0000;
    applyStimulus();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0100) $display("[TB] FAIL route_valid got=%b exp=0100", out_valid); else passes++;
    checks++;
    if (out_c !== 32'hDEADBEEF) $display("[TB] FAIL route_data got=%h exp=deadbeef", out_c); else passes++;
    checks++;
    if (accept_cnt !== 16'd1) $display("[TB] FAIL route_cnt got=%0d exp=1", accept_cnt); else passes++;
    out_ready = 4'b0100;
    applyStimulus();
    out_ready = 4'b0000;
    checks++;
    if (out_valid !== 4'b0000) $display("[TB] FAIL route_drain got=%b exp=0000", out_valid); else passes++;
  endtask

  task automatic test_backpressure();
    in_sel = 2'b01; in_data = 32'h1111; in_valid = 1'b1;
    applyStimulus();
    in_data = 32'h2222;
    #1;
    checks++;
    if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready got=%b exp=0", in_ready); else passes++;
    applyStimulus();
    checks++;
    if (out_b !== 32'h1111 || out_valid !== 4'b0010) $display("[TB] FAIL bp_hold got=%h/%b exp=1111/0010", out_b, out_valid); else passes++;
    checks++;
    if (accept_cnt !== 16'd2) $display("[TB] FAIL bp_cnt got=%0d exp=2", accept_cnt); else passes++;
    in_sel = 2'b11; in_data = 32'h3333;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL bp_other_ready got=%b exp=1", in_ready); else passes++;
    applyStimulus();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b1010 || out_d !== 32'h3333 || out_b !== 32'h1111) $display("[TB] FAIL bp_other_load got=%b d=%h b=%h exp=1010 3333 1111", out_valid, out_d, out_b); else passes++;
    checks++;
    if (accept_cnt !== 16'd3) $display("[TB] FAIL bp_other_cnt got=%0d exp=3", accept_cnt); else passes++;
  endtask

  task automatic test_valid_low();
    in_valid = 1'b0; in_sel = 2'b00; in_data = 32'hBAD;
    applyStimulus();
    checks++;
    if (out_valid !== 4'b1010 || accept_cnt !== 16'd3) $display("[TB] FAIL valid_low got=%b/%0d exp=1010/3", out_valid, accept_cnt); else passes++;
  endtask

  task automatic test_pass_through();
    out_ready = 4'b1010;
    applyStimulus();
    out_ready = 4'b0000;
    checks++;
    if (out_valid !== 4'b0000) $display("[TB] FAIL pt_drain_bd got=%b exp=0000", out_valid); else passes++;
    in_sel = 2'b00; in_data = 32'h1; in_valid = 1'b1;
    applyStimulus();
    in_data = 32'h2; out_ready = 4'b0001;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid[0] !== 1'b1) $display("[TB] FAIL pt_ready got=%b/%b exp=1/1", in_ready, out_valid[0]); else passes++;
    applyStimulus();
    in_valid = 1'b0; out_ready = 4'b0000;
    checks++;
    if (out_valid !== 4'b0001 || out_a !== 32'h2) $display("[TB] FAIL pt_replace got=%b a=%h exp=0001 2", out_valid, out_a); else passes++;
    checks++;
    if (accept_cnt !== 16'd5) $display("[TB] FAIL pt_cnt got=%0d exp=5", accept_cnt); else passes++;
  endtask

  task automatic test_parallel_drain();
    in_valid = 1'b1;
    in_sel = 2'b01; in_data = 32'hB0; applyStimulus();
    in_sel = 2'b10; in_data = 32'hC0; applyStimulus();
    in_sel = 2'b11; in_data = 32'h44; out_ready = 4'b0110;
    applyStimulus();
    in_valid = 1'b0; out_ready = 4'b0000;
    checks++;
    if (out_valid !== 4'b1001 || out_d !== 32'h44 || out_a !== 32'h2) $display("[TB] FAIL parallel got=%b d=%h a=%h exp=1001 44 2", out_valid, out_d, out_a); else passes++;
  endtask

  task automatic test_mid_reset();
    out_ready = 4'b1111;
    applyStimulus();
    out_ready = 4'b0000; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sel = 2'(i); in_data = 32'hA0 + 32'(i) * 32'h10;
      applyStimulus();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b1111 || out_a !== 32'hA0 || out_b !== 32'hB0 || out_c !== 32'hC0 || out_d !== 32'hD0)
      $display("[TB] FAIL mid_fill got=%b %h %h %h %h exp=1111 a0 b0 c0 d0", out_valid, out_a, out_b, out_c, out_d);
    else passes++;
    rst = 1'b1; in_valid = 1'b1; in_sel = 2'b00;
    applyStimulus();
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0000 || {out_a, out_b, out_c, out_d} !== 128'h0 || accept_cnt !== 16'd0)
      $display("[TB] FAIL mid_reset got=%b %h %h %h %h cnt=%0d exp=0", out_valid, out_a, out_b, out_c, out_d, accept_cnt);
    else passes++;
  endtask

  task automatic test_counter_wrap();
    in_sel = 2'b00; in_data = 32'h77; in_valid = 1'b1; out_ready = 4'b0001;
    repeat (65535) @(posedge clk);
    #1;
    checks++;
    if (accept_cnt !== 16'hFFFF) $display("[TB] FAIL wrap_preload got=%h exp=ffff", accept_cnt); else passes++;
    applyStimulus();
    in_valid = 1'b0; out_ready = 4'b0000;
    checks++;
    if (accept_cnt !== 16'h0000) $display("[TB] FAIL wrap got=%h exp=0000", accept_cnt); else passes++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = '0;
    test_reset();
    test_route();
    test_backpressure();
    test_valid_low();
    test_pass_through();
    test_parallel_drain();
    test_mid_reset();
    test_counter_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/demux_1x4_buf.md
DEMUX_1X4_BUF -- requirements
Module: demux_1x4_buf

Interface
REQ-001 The module SHALL have parameter Bits, default 32, giving the data width of the input and of each output lane.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 The module SHALL have port in_data, input, Bits, the word to be routed.
REQ-005 The module SHALL have port in_sel, input, 2 bits, the destination lane: 00=a, 01=b, 10=c, 11=d.
REQ-006 The module SHALL have port in_valid, input, 1 bit, meaning in_data/in_sel are valid.
REQ-007 The module SHALL have port in_ready, output, 1 bit, meaning the lane selected by in_sel can accept this cycle.
REQ-008 The module SHALL have ports out_a, out_b, out_c, out_d, outputs, Bits each, carrying the lane buffer contents.
REQ-009 The module SHALL have port out_valid, output, 4 bits; bit 0 = lane a, bit 1 = b, bit 2 = c, bit 3 = d.
REQ-010 The module SHALL have port out_ready, input, 4 bits, per-lane consumer ready with the same bit mapping.
REQ-011 The module SHALL have port accept_cnt, output, 16 bits, the count of accepted input words.

Function
REQ-012 Each lane SHALL hold a one-entry buffer: valid flag plus Bits-wide data register.
REQ-013 out_valid[i] and out_<lane> SHALL be driven directly from lane i's valid flag and data register.
REQ-014 in_ready SHALL be combinational: (lane[in_sel] valid flag = 0, or out_ready[in_sel] = 1), and rst = 0.
REQ-015 An accept SHALL occur in a cycle when in_valid = 1 and in_ready = 1.
REQ-016 On accept, lane[in_sel] SHALL load in_data and set its valid flag at the next rising edge; latency is 1 cycle.
REQ-017 A drain SHALL occur on lane i in a cycle when out_valid[i] = 1 and out_ready[i] = 1; the valid flag clears at the next edge unless the lane is loaded in the same cycle.
REQ-018 Simultaneous drain and load of the same lane SHALL replace the data with in_data and keep valid = 1, with no bubble.
REQ-019 Lanes not selected SHALL be unaffected by an accept; drains on different lanes SHALL proceed independently in the same cycle.
REQ-020 While out_valid[i] = 1 and out_ready[i] = 0, out_<lane i> SHALL hold stable.
REQ-021 in_sel and in_data MAY change while in_valid = 1 and not accepted; the block SHALL evaluate in_ready against the current in_sel each cycle.
REQ-022 When in_valid = 0, no lane SHALL be loaded, regardless of in_sel or in_data.
REQ-023 accept_cnt SHALL increment by 1 at the edge following each accept and wrap from 0xFFFF to 0x0000.
REQ-024 At most one accept SHALL occur per cycle.

Reset
REQ-025 With rst = 1 at a rising edge, all lane valid flags SHALL clear to 0, all lane data registers to 0, and accept_cnt to 0.
REQ-026 While rst = 1, in_ready SHALL be 0 and no accept SHALL be counted.
REQ-027 Reset mid-operation SHALL discard all buffered words without any drain handshake.

Verification
REQ-028 Reset then idle: rst high 2 cycles -> out_valid = 0000, out_a..out_d = 0, accept_cnt = 0, in_ready = 0 during reset and 1 after.
REQ-029 Route test: in_sel = 10, in_data = 0xDEADBEEF, valid 1 cycle, out_ready = 0000 -> next cycle out_valid = 0100, out_c = 0xDEADBEEF, accept_cnt = 1.
REQ-030 Backpressure: lane b full, out_ready[1] = 0, in_sel = 01, in_valid = 1 -> in_ready = 0 and out_b unchanged; with in_sel = 11 -> in_ready = 1 and lane d loads.
REQ-031 Pass-through: lane a full with 0x1, out_ready[0] = 1, accept 0x2 to lane a -> next cycle out_valid[0] = 1, out_a = 0x2, lane a valid never drops.
REQ-032 Counter wrap: accept_cnt preloaded to 0xFFFF via 65535 accepts, then one more accept -> accept_cnt = 0x0000.
REQ-033 Mid-operation reset: all four lanes full with distinct values, rst for 1 cycle -> out_valid = 0000, outputs 0, accept_cnt = 0.
